// File: rtl/adder_result_collector_if.sv
// Valid/ready drain port of the adder result collector.
// The collector drives valid/data as master; the consumer drives ready.
interface adder_result_collector_if #(
   parameter int DATA_W = 7
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/adder_result_collector.sv
// Captures the adder's registered result a fixed latency after each issue,
// buffers it in a small FIFO, and keeps saturating sum/count plus a sticky drop flag.
module adder_result_collector #(
   parameter int DATA_W  = 7,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 1,
   parameter int SUM_W   = 16,
   parameter int CNT_W   = 8,
   localparam int PW     = $clog2(DEPTH),
   localparam int LW     = PW + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic [DATA_W-1:0]        c,
   input  logic                     clear_stats,
   adder_result_collector_if.master out_if,
   output logic [SUM_W-1:0]         sum,
   output logic [CNT_W-1:0]         count,
   output logic                     drop,
   output logic [LW-1:0]            level
);

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [LATENCY-1:0] issue_sr_q, issue_sr_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0]  mem_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               out_valid_q, out_valid_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               drop_q, drop_d;

   logic               cap_s, full_s, pop_s, push_s, drop_ev_s;
   logic [SUM_W:0]     sum_wide_s;

   // Next-state logic for capture pipe, FIFO and statistics.
   always_comb begin
      issue_sr_d[0] = issue_valid;
      for (int i = 1; i < LATENCY; i++) begin
         issue_sr_d[i] = issue_sr_q[i-1];
      end
      cap_s     = issue_sr_q[LATENCY-1];
      full_s    = (level_q == FULL_LVL);
      pop_s     = out_valid_q & out_if.out_ready;
      // A coincident pop frees the slot, so a full FIFO still accepts the push.
      push_s    = cap_s & (~full_s | pop_s);
      drop_ev_s = cap_s & full_s & ~pop_s;

      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = c;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end

      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      out_valid_d = (level_d != {LW{1'b0}});

      sum_wide_s = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, c};
      if (clear_stats) begin
         sum_d   = {SUM_W{1'b0}};
         count_d = {CNT_W{1'b0}};
         drop_d  = 1'b0;
      end else begin
         if (push_s) begin
            sum_d   = sum_wide_s[SUM_W] ? {SUM_W{1'b1}} : sum_wide_s[SUM_W-1:0];
            count_d = (count_q == {CNT_W{1'b1}}) ? count_q : (count_q + CNT_W'(1));
         end else begin
            sum_d   = sum_q;
            count_d = count_q;
         end
         drop_d = drop_q | drop_ev_s;
      end
   end

   // State registers; reset clears the in-flight pipe and zeroes every FIFO entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_sr_q  <= {LATENCY{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         level_q     <= {LW{1'b0}};
         out_valid_q <= 1'b0;
         sum_q       <= {SUM_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         drop_q      <= 1'b0;
      end else begin
         issue_sr_q  <= issue_sr_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
      end
   end

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = mem_q[rd_ptr_q];
   assign sum              = sum_q;
   assign count            = count_q;
   assign drop             = drop_q;
   assign level            = level_q;

endmodule
